morty_decode_ctrl: RTL and testbench
====================================

# morty_decode_ctrl

Decode-stage controller for the Morty RV32I core: sits between fetch and execute, registers each fetched instruction behind a valid/ready handshake, and decodes its opcode into the 3-bit immediate-format select that steers the immediate generator. A two-entry skid buffer sustains one instruction per cycle under back-pressure. A synchronous flush clears both entries on a taken branch or jump.

## Interface
- No parameters. Data width is fixed at 32.
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered instructions this cycle.
- if_valid_i  in  1  fetch presents an instruction.
- if_ready_o  out  1  decode can accept; transfer when if_valid_i && if_ready_o.
- if_instr_i  in  32  fetched instruction word.
- if_pc_i  in  32  PC of the fetched instruction.
- id_valid_o  out  1  decoded instruction available to execute.
- id_ready_i  in  1  execute consumes; transfer when id_valid_o && id_ready_i.
- id_instr_o  out  32  instruction word, which is fed to the immediate generator.
- id_pc_o  out  32  PC of id_instr_o.
- imm_sel_o  out  3  immediate-format select for id_instr_o.
- illegal_o  out  1  id_instr_o has an unsupported opcode; qualified by id_valid_o.

## Operation
- Decode (opcode = instr[6:0]) is computed at the input and stored with each entry:
  - 0010011 OP-IMM with funct3 001 or 101 -> 011 (shamt).
  - Other 0010011, plus 0000011 LOAD and 1100111 JALR -> 000 (I-type).
  - 0100011 STORE -> 001 (S).
  - 1100011 BRANCH -> 010 (B).
  - 1101111 JAL -> 100 (J).
  - 0110111 LUI and 0010111 AUIPC -> 101 (U).
  - 0110011 OP, 0001111 FENCE and 1110011 SYSTEM -> 110 (no immediate; the immediate generator outputs 0).
  - Any other opcode -> 110, and the entry is marked illegal.
- Storage: a main register (drives the id_* outputs) and a skid register. Each holds {instr, pc, imm_sel, illegal, valid}.
- States are encoded by the valid bits:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: main valid, skid valid.
- Transitions (acc = input transfer, pop = output transfer):
  - EMPTY: acc -> FULL, input loads main.
  - FULL:
    - acc && pop -> FULL, input loads main.
    - acc && !pop -> SKID, input loads skid.
    - !acc && pop -> EMPTY.
    - Otherwise hold.
  - SKID: if_ready_o is 0, so there is no acc.
    - pop -> FULL, skid moves to main.
    - Otherwise hold.
- if_ready_o = !skid_valid && !rst_i && !flush_i. It never depends combinationally on id_ready_i.
- Flush: next state is EMPTY regardless of acc/pop. An input handshake in the flush cycle is impossible (if_ready_o = 0). A pop coincident with flush completes normally.
- Reset, next edge: state EMPTY. id_valid_o=0, id_instr_o=0, id_pc_o=0, imm_sel_o=3'b110, illegal_o=0. if_ready_o=0 while rst_i is high.
- Reset or flush mid-stream: buffered entries are lost with no partial transfer. Reset has priority over flush.
- id_* outputs are stable while id_valid_o && !id_ready_i.

## Timing
- Latency: an instruction accepted at edge N appears on the id_* outputs after edge N, so execute sees it in cycle N+1.
- Throughput: 1 instruction/cycle while id_ready_i stays high.
- When id_ready_i falls, at most one extra instruction is absorbed (into skid). if_ready_o drops the cycle after.
- When id_ready_i rises in SKID: main pops that cycle, skid moves to main at the edge, and if_ready_o = 1 in the next cycle.
- All outputs are registered or derived from registers only. The exception is if_ready_o, which is gated combinationally by rst_i and flush_i.

## Configuration
- MORTY_ILLEGAL_TRAP_EN defined:
  - Unsupported opcodes set illegal_o with their entry.
  - Execute raises the illegal-instruction trap from illegal_o.
- MORTY_ILLEGAL_TRAP_EN undefined:
  - The illegal storage bit is removed.
  - illegal_o is tied 0.
  - Unsupported opcodes pass as imm_sel 110, behaving like a NOP.

## Test plan
- Reset then stream: hold rst_i 2 cycles, then offer 0x00500093 (addi) at pc 0x0 with id_ready_i=1 -> id_valid_o=1 the next cycle, imm_sel_o=000, id_pc_o=0x0, illegal_o=0.
- Format sweep: stream sw 0x00112023, beq 0x00000463, slli 0x00209093, jal 0x008000EF, lui 0x123450B7, add 0x002081B3 -> imm_sel_o = 001, 010, 011, 100, 101, 110 on consecutive cycles, with no bubbles.
- Back-pressure: with a continuous stream, drop id_ready_i at cycle 5 for 3 cycles.
  - if_ready_o falls after exactly one extra accept.
  - id_instr_o is held.
  - After release, all instructions emerge in order with none lost or duplicated.
- Flush: in SKID state, assert flush_i for 1 cycle -> id_valid_o=0 and if_ready_o=1 the next cycle; the next accepted instruction is the first output.
- Illegal opcode: offer 0x0000007F.
  - With MORTY_ILLEGAL_TRAP_EN: illegal_o=1 and imm_sel_o=110.
  - Without it: illegal_o=0 and imm_sel_o=110.
- Reset mid-stream: assert rst_i while in SKID state -> id_valid_o=0 and all outputs at their reset values after the edge.

Source files
------------

// File: rtl/morty_decode_ctrl.sv
// morty_decode_ctrl: decode-stage controller for the Morty RV32I core.
// Registers fetched instructions behind a valid/ready handshake with a
// two-entry (main + skid) buffer and decodes each opcode into the 3-bit
// immediate-format select used by the immediate generator.
// Optional feature macro: MORTY_ILLEGAL_TRAP_EN keeps a per-entry illegal
// bit and drives illegal_o; without it illegal_o is tied low and unknown
// opcodes flow through as no-immediate NOPs.
module morty_decode_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [2:0]  imm_sel_o,
  output logic        illegal_o
);

  // Buffer occupancy, encoded as {skid_valid, main_valid}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_SHAMT = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_U     = 3'b101;
  localparam logic [2:0] IMM_NONE  = 3'b110;

  logic        main_valid, skid_valid;
  logic [31:0] main_instr, main_pc, skid_instr, skid_pc;
  logic [2:0]  main_imm_sel, skid_imm_sel;
  logic [2:0]  dec_imm_sel;

  logic acc, pop;
  logic load_main_in, load_main_skid, load_skid;
  logic main_valid_nxt, skid_valid_nxt;

  assign if_ready_o = !skid_valid && !rst_i && !flush_i;
  assign acc        = if_valid_i && if_ready_o;
  assign pop        = main_valid && id_ready_i;

  // Opcode decode at the input so each entry carries its own format select.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_imm_sel = IMM_NONE;
    case (if_instr_i[6:0])
      OPC_OP_IMM:          dec_imm_sel = (if_instr_i[13:12] == 2'b01) ? IMM_SHAMT : IMM_I;
      OPC_LOAD, OPC_JALR:  dec_imm_sel = IMM_I;
      OPC_STORE:           dec_imm_sel = IMM_S;
      OPC_BRANCH:          dec_imm_sel = IMM_B;
      OPC_JAL:             dec_imm_sel = IMM_J;
      OPC_LUI, OPC_AUIPC:  dec_imm_sel = IMM_U;
      default:             dec_imm_sel = IMM_NONE;
    endcase
  end

  // Next-occupancy and load steering for the main/skid pair.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case ({skid_valid, main_valid})
      ST_EMPTY: begin
        if (acc) begin
          load_main_in   = 1'b1;
          main_valid_nxt = 1'b1;
        end
      end
      ST_FULL: begin
        if (acc && pop) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          load_skid      = 1'b1;
          skid_valid_nxt = 1'b1;
        end else if (pop) begin
          main_valid_nxt = 1'b0;
        end
      end
      ST_SKID: begin
        if (pop) begin
          load_main_skid = 1'b1;
          skid_valid_nxt = 1'b0;
        end
      end
      default: begin
        main_valid_nxt = 1'b0;
        skid_valid_nxt = 1'b0;
      end
    endcase
    if (flush_i) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end
  end

  // Valid bits: reset has priority, flush is folded into the next-state logic.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
    end
  end

  // Main entry payload; reset because it drives the visible id_* outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_instr   <= '0;
      main_pc      <= '0;
      main_imm_sel <= IMM_NONE;
    end else if (load_main_in) begin
      main_instr   <= if_instr_i;
      main_pc      <= if_pc_i;
      main_imm_sel <= dec_imm_sel;
    end else if (load_main_skid) begin
      main_instr   <= skid_instr;
      main_pc      <= skid_pc;
      main_imm_sel <= skid_imm_sel;
    end
  end

  // Skid entry payload.
  always_ff @(posedge clk_i) begin
    // NOTE: skid payload has no reset; it is never observed unless skid_valid is set.
    if (load_skid) begin
      skid_instr   <= if_instr_i;
      skid_pc      <= if_pc_i;
      skid_imm_sel <= dec_imm_sel;
    end
  end

`ifdef MORTY_ILLEGAL_TRAP_EN
  logic dec_illegal, main_illegal, skid_illegal;

  // Flag opcodes outside the supported RV32I set.
  always_comb begin
    dec_illegal = 1'b1;
    case (if_instr_i[6:0])
      OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: dec_illegal = 1'b0;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Illegal bit travels with its entry exactly like the payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_illegal <= 1'b0;
    end else if (load_main_in) begin
      main_illegal <= dec_illegal;
    end else if (load_main_skid) begin
      main_illegal <= skid_illegal;
    end
  end

  // Skid copy of the illegal bit.
  always_ff @(posedge clk_i) begin
    if (load_skid) begin
      skid_illegal <= dec_illegal;
    end
  end

  assign illegal_o = main_illegal;
`else
  assign illegal_o = 1'b0;
`endif

  assign id_valid_o = main_valid;
  assign id_instr_o = main_instr;
  assign id_pc_o    = main_pc;
  assign imm_sel_o  = main_imm_sel;

endmodule

// File: tb/tb_morty_decode_ctrl.sv
// Directed testbench for morty_decode_ctrl.
module tb_morty_decode_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        if_valid_i = 1'b0;
  logic        if_ready_o;
  logic [31:0] if_instr_i = '0;
  logic [31:0] if_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b1;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [2:0]  imm_sel_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  morty_decode_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .if_ready_o (if_ready_o),
    .if_instr_i (if_instr_i),
    .if_pc_i    (if_pc_i),
    .id_valid_o (id_valid_o),
    .id_ready_i (id_ready_i),
    .id_instr_o (id_instr_o),
    .id_pc_o    (id_pc_o),
    .imm_sel_o  (imm_sel_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    if_valid_i = 1'b0;
    flush_i    = 1'b0;
    id_ready_i = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    if_valid_i = 1'b0;
    id_ready_i = 1'b1;
    tick();
    checks++;
    if (if_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", if_ready_o); end
    tick();
    checks++;
    if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
    checks++;
    if (id_instr_o !== 32'h0 || id_pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_data: instr %h pc %h want 0/0", id_instr_o, id_pc_o);
    end
    checks++;
    if (imm_sel_o !== 3'b110 || illegal_o !== 1'b0) begin
      errors++; $display("FAIL reset_sel: imm %b ill %b want 110/0", imm_sel_o, illegal_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (if_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", if_ready_o); end
  endtask

  task automatic test_first_instr();
    if_valid_i = 1'b1;
    if_instr_i = 32'h00500093;
    if_pc_i    = 32'h0;
    id_ready_i = 1'b1;
    tick();
    if_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || imm_sel_o !== 3'b000 || id_pc_o !== 32'h0 || illegal_o !== 1'b0 ||
        id_instr_o !== 32'h00500093) begin
      errors++;
      $display("FAIL first_instr: v %b imm %b pc %h ill %b instr %h want 1/000/0/0/00500093",
               id_valid_o, imm_sel_o, id_pc_o, illegal_o, id_instr_o);
    end
    tick();
    checks++;
    if (id_valid_o !== 1'b0) begin errors++; $display("FAIL first_drain: got %b want 0", id_valid_o); end
  endtask

  task automatic test_format_sweep();
    logic [31:0] instrs [6] = '{32'h00112023, 32'h00000463, 32'h00209093,
                                32'h008000EF, 32'h123450B7, 32'h002081B3};
    logic [2:0]  sels   [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    id_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if_valid_i = 1'b1;
      if_instr_i = instrs[i];
      if_pc_i    = 32'h40 + 32'(4 * i);
      #1;
      checks++;
      if (if_ready_o !== 1'b1) begin errors++; $display("FAIL sweep_ready[%0d]: got %b want 1", i, if_ready_o); end
      tick();
      checks++;
      if (id_valid_o !== 1'b1 || id_instr_o !== instrs[i] || imm_sel_o !== sels[i] ||
          id_pc_o !== 32'h40 + 32'(4 * i)) begin
        errors++;
        $display("FAIL sweep[%0d]: v %b instr %h imm %b pc %h want 1/%h/%b/%h", i, id_valid_o,
                 id_instr_o, imm_sel_o, id_pc_o, instrs[i], sels[i], 32'h40 + 32'(4 * i));
      end
    end
    drain();
  endtask

  // Stream ten addi's, id_ready_i low in cycles 5..7; expect one skid absorb.
  task automatic test_back_pressure();
    int next = 0;
    int popped = 0;
    logic exp_ready;
    logic [31:0] exp_instr;
    for (int c = 0; c < 16; c++) begin
      id_ready_i = !(c >= 5 && c <= 7);
      if_valid_i = (next < 10);
      if_instr_i = 32'h00000093 | (32'(next) << 20);
      if_pc_i    = 32'h100 + 32'(4 * next);
      #1;
      exp_ready = !(c >= 6 && c <= 8);
      checks++;
      if (if_ready_o !== exp_ready) begin
        errors++; $display("FAIL bp_ready[c%0d]: got %b want %b", c, if_ready_o, exp_ready);
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (id_valid_o !== 1'b1 || id_instr_o !== 32'h00400093) begin
          errors++; $display("FAIL bp_hold[c%0d]: v %b instr %h want 1/00400093", c, id_valid_o, id_instr_o);
        end
      end
      if (id_valid_o === 1'b1 && id_ready_i) begin
        exp_instr = 32'h00000093 | (32'(popped) << 20);
        checks++;
        if (id_instr_o !== exp_instr || id_pc_o !== 32'h100 + 32'(4 * popped)) begin
          errors++;
          $display("FAIL bp_order[%0d]: instr %h pc %h want %h/%h", popped, id_instr_o, id_pc_o,
                   exp_instr, 32'h100 + 32'(4 * popped));
        end
        popped++;
      end
      if (if_valid_i && if_ready_o === 1'b1) next++;
      tick();
    end
    checks++;
    if (popped != 10 || next != 10) begin
      errors++; $display("FAIL bp_count: popped %0d accepted %0d want 10/10", popped, next);
    end
    drain();
  endtask

  // Fill main and skid with id_ready_i low.
  task automatic fill_skid(input logic [31:0] base);
    id_ready_i = 1'b0;
    if_valid_i = 1'b1;
    if_instr_i = 32'h00000013 | (base << 20);
    if_pc_i    = base;
    tick();
    if_instr_i = 32'h00100013 | (base << 20);
    if_pc_i    = base + 32'h4;
    tick();
    if_valid_i = 1'b0;
    #1;
    checks++;
    if (if_ready_o !== 1'b0 || id_valid_o !== 1'b1) begin
      errors++; $display("FAIL skid_fill: ready %b valid %b want 0/1", if_ready_o, id_valid_o);
    end
  endtask

  task automatic test_flush();
    fill_skid(32'h200);
    flush_i    = 1'b1;
    if_valid_i = 1'b1;
    if_instr_i = 32'h00A00113;
    if_pc_i    = 32'h300;
    #1;
    checks++;
    if (if_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_comb: got %b want 0", if_ready_o); end
    tick();
    flush_i = 1'b0;
    #1;
    checks++;
    if (id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_after: valid %b ready %b want 0/1", id_valid_o, if_ready_o);
    end
    id_ready_i = 1'b1;
    tick();
    if_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || id_instr_o !== 32'h00A00113 || id_pc_o !== 32'h300) begin
      errors++; $display("FAIL flush_next: v %b instr %h pc %h want 1/00a00113/300", id_valid_o, id_instr_o, id_pc_o);
    end
    tick();
    checks++;
    if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drain: got %b want 0", id_valid_o); end
  endtask

  task automatic test_illegal();
    logic exp_ill;
`ifdef MORTY_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    id_ready_i = 1'b1;
    if_valid_i = 1'b1;
    if_instr_i = 32'h0000007F;
    if_pc_i    = 32'h500;
    tick();
    checks++;
    if (id_valid_o !== 1'b1 || imm_sel_o !== 3'b110 || illegal_o !== exp_ill) begin
      errors++; $display("FAIL illegal: v %b imm %b ill %b want 1/110/%b", id_valid_o, imm_sel_o, illegal_o, exp_ill);
    end
    if_instr_i = 32'h0000000F;
    if_pc_i    = 32'h504;
    tick();
    if_valid_i = 1'b0;
    checks++;
    if (imm_sel_o !== 3'b110 || illegal_o !== 1'b0 || id_pc_o !== 32'h504) begin
      errors++; $display("FAIL fence_legal: imm %b ill %b pc %h want 110/0/504", imm_sel_o, illegal_o, id_pc_o);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    fill_skid(32'h600);
    rst_i = 1'b1;
    id_ready_i = 1'b1;
    #1;
    checks++;
    if (if_ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", if_ready_o); end
    tick();
    checks++;
    if (id_valid_o !== 1'b0 || id_instr_o !== 32'h0 || id_pc_o !== 32'h0 ||
        imm_sel_o !== 3'b110 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: v %b instr %h pc %h imm %b ill %b want 0/0/0/110/0",
               id_valid_o, id_instr_o, id_pc_o, imm_sel_o, illegal_o);
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if (id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_release: valid %b ready %b want 0/1", id_valid_o, if_ready_o);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_instr();
    test_format_sweep();
    test_back_pressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
